// File: rtl/bfly_buf_pkg.sv
// Shared types and helpers for the butterfly pair buffer.
// Optional feature macro: BFLY_PAIR_BUF_BLKCNT_EN (adds the blk_cnt block counter).
package bfly_buf_pkg;

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } state_t;

  localparam int unsigned BLK_CNT_WIDTH = 16;

  // Beat counter width for a butterfly span of depth beats.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bfly_pair_buf_if.sv
// Beat input / butterfly pair output bundle for bfly_pair_buf.
// Optional feature macro: BFLY_PAIR_BUF_BLKCNT_EN (adds blk_cnt).
interface bfly_pair_buf_if #(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned LANES      = 16
);
  logic                             din_valid;
  logic [LANES-1:0][DATA_WIDTH-1:0] din_i;
  logic [LANES-1:0][DATA_WIDTH-1:0] din_q;
  logic                             flush;
  logic [LANES-1:0][DATA_WIDTH-1:0] top_i;
  logic [LANES-1:0][DATA_WIDTH-1:0] top_q;
  logic [LANES-1:0][DATA_WIDTH-1:0] bot_i;
  logic [LANES-1:0][DATA_WIDTH-1:0] bot_q;
  logic                             pair_valid;
  logic                             blk_last;
  logic                             phase;
`ifdef BFLY_PAIR_BUF_BLKCNT_EN
  logic [15:0]                      blk_cnt;

  modport master (
    output din_valid, din_i, din_q, flush,
    input  top_i, top_q, bot_i, bot_q, pair_valid, blk_last, phase, blk_cnt
  );

  modport slave (
    input  din_valid, din_i, din_q, flush,
    output top_i, top_q, bot_i, bot_q, pair_valid, blk_last, phase, blk_cnt
  );
`else
  modport master (
    output din_valid, din_i, din_q, flush,
    input  top_i, top_q, bot_i, bot_q, pair_valid, blk_last, phase
  );

  modport slave (
    input  din_valid, din_i, din_q, flush,
    output top_i, top_q, bot_i, bot_q, pair_valid, blk_last, phase
  );
`endif
endinterface

// File: rtl/bfly_delay_line.sv
// Enable-gated DEPTH-beat I/Q shift storage; out_* is the beat accepted DEPTH beats ago.
module bfly_delay_line #(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned LANES      = 16,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] in_i,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] in_q,
  output logic [LANES-1:0][DATA_WIDTH-1:0] out_i,
  output logic [LANES-1:0][DATA_WIDTH-1:0] out_q
);

  typedef logic [LANES-1:0][DATA_WIDTH-1:0] beat_t;

  beat_t sr_i [DEPTH];
  beat_t sr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        sr_i[k] <= '0;
        sr_q[k] <= '0;
      end
    end else if (en) begin
      sr_i[0] <= in_i;
      sr_q[0] <= in_q;
      for (int k = 1; k < int'(DEPTH); k++) begin
        sr_i[k] <= sr_i[k-1];
        sr_q[k] <= sr_q[k-1];
      end
    end
  end

  assign out_i = sr_i[DEPTH-1];
  assign out_q = sr_q[DEPTH-1];

endmodule

// File: rtl/bfly_pair_buf.sv
// Butterfly pair buffer: pairs beat x[n] with x[n+DEPTH] over blocks of 2*DEPTH beats.
// Optional feature macro: BFLY_PAIR_BUF_BLKCNT_EN (saturating completed-block counter).
module bfly_pair_buf
  import bfly_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned LANES      = 16,
  parameter int unsigned DEPTH      = 16
) (
  input  logic            clk,
  input  logic            rst,
  bfly_pair_buf_if.slave  bus
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH - 1);

  typedef logic [LANES-1:0][DATA_WIDTH-1:0] beat_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  beat_t         old_i;
  beat_t         old_q;
  beat_t         top_i;
  beat_t         top_q;
  beat_t         bot_i;
  beat_t         bot_q;
  logic          pair_valid;
  logic          blk_last;

  // flush drops a concurrent beat
  assign accept = bus.din_valid & ~bus.flush;

  bfly_delay_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .DEPTH      (DEPTH)
  ) u_delay (
    .clk   (clk),
    .rst   (rst),
    .en    (accept),
    .in_i  (bus.din_i),
    .in_q  (bus.din_q),
    .out_i (old_i),
    .out_q (old_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      cnt        <= '0;
      pair_valid <= 1'b0;
      blk_last   <= 1'b0;
      top_i      <= '0;
      top_q      <= '0;
      bot_i      <= '0;
      bot_q      <= '0;
    end else if (bus.flush) begin
      state      <= FILL;
      cnt        <= '0;
      pair_valid <= 1'b0;
      blk_last   <= 1'b0;
    end else begin
      pair_valid <= 1'b0;
      blk_last   <= 1'b0;
      if (accept) begin
        // DEPTH is a power of two, so the counter wraps to 0 on its own
        cnt <= cnt + CW'(1);
        case (state)
          FILL: begin
            if (cnt == CNT_MAX) state <= PAIR;
          end
          PAIR: begin
            top_i      <= old_i;
            top_q      <= old_q;
            bot_i      <= bus.din_i;
            bot_q      <= bus.din_q;
            pair_valid <= 1'b1;
            if (cnt == CNT_MAX) begin
              blk_last <= 1'b1;
              state    <= FILL;
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

`ifdef BFLY_PAIR_BUF_BLKCNT_EN
  logic [BLK_CNT_WIDTH-1:0] blk_cnt;

  // counts on the edge that raises blk_last; only rst clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt <= '0;
    end else if (accept && state == PAIR && cnt == CNT_MAX && blk_cnt != '1) begin
      blk_cnt <= blk_cnt + BLK_CNT_WIDTH'(1);
    end
  end

  assign bus.blk_cnt = blk_cnt;
`endif

  assign bus.top_i      = top_i;
  assign bus.top_q      = top_q;
  assign bus.bot_i      = bot_i;
  assign bus.bot_q      = bot_q;
  assign bus.pair_valid = pair_valid;
  assign bus.blk_last   = blk_last;
  assign bus.phase      = 1'(state);

endmodule

// File: tb/tb_bfly_pair_buf.sv
// Directed bench for bfly_pair_buf at DEPTH=4, LANES=2, DATA_WIDTH=9.
// Lane 0 carries +v, lane 1 carries -v; Q samples are offset by 50 from I.
module tb_bfly_pair_buf;

  localparam int unsigned DW    = 9;
  localparam int unsigned LN    = 2;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bfly_pair_buf_if #(.DATA_WIDTH(DW), .LANES(LN)) bus ();

  bfly_pair_buf #(
    .DATA_WIDTH (DW),
    .LANES      (LN),
    .DEPTH      (DEPTH)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] lanes(input int v);
    logic [8:0] lo;
    logic [8:0] hi;
    lo = 9'(v);
    hi = 9'(-v);
    return {hi, lo};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic drive(input int v, input bit valid, input bit fl, input bit r);
    @(negedge clk);
    bus.din_valid = valid;
    bus.flush     = fl;
    rst           = r;
    bus.din_i     = lanes(v);
    bus.din_q     = lanes(v + 50);
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int v);
    drive(v, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic exp_none(input string tag);
    check({tag, ".pv"}, 32'(bus.pair_valid), 32'd0);
    check({tag, ".last"}, 32'(bus.blk_last), 32'd0);
  endtask

  task automatic exp_pair(input string tag, input int t, input int b, input bit last);
    check({tag, ".pv"}, 32'(bus.pair_valid), 32'd1);
    check({tag, ".last"}, 32'(bus.blk_last), 32'(last));
    check({tag, ".top_i"}, 32'(bus.top_i), 32'(lanes(t)));
    check({tag, ".top_q"}, 32'(bus.top_q), 32'(lanes(t + 50)));
    check({tag, ".bot_i"}, 32'(bus.bot_i), 32'(lanes(b)));
    check({tag, ".bot_q"}, 32'(bus.bot_q), 32'(lanes(b + 50)));
  endtask

  task automatic do_reset();
    drive(0, 1'b0, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b0, 1'b1);
    check("rst.pv", 32'(bus.pair_valid), 32'd0);
    check("rst.last", 32'(bus.blk_last), 32'd0);
    check("rst.phase", 32'(bus.phase), 32'd0);
    check("rst.top", 32'({bus.top_q, bus.top_i}), 32'd0);
    check("rst.bot", 32'({bus.bot_q, bus.bot_i}), 32'd0);
    idle();
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.din_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.din_i     = '0;
    bus.din_q     = '0;

    // contiguous block 0..7
    do_reset();
    for (int b = 0; b < 4; b++) begin
      beat(b);
      exp_none("fill");
    end
    check("fill.phase", 32'(bus.phase), 32'd1);
    beat(4); exp_pair("p0", 0, 4, 1'b0);
    beat(5); exp_pair("p1", 1, 5, 1'b0);
    beat(6); exp_pair("p2", 2, 6, 1'b0);
    beat(7); exp_pair("p3", 3, 7, 1'b1);
    check("wrap.phase", 32'(bus.phase), 32'd0);

    // same stream with a gap after every beat; outputs hold during gaps
    do_reset();
    for (int b = 0; b < 8; b++) begin
      beat(b);
      if (b < 4) exp_none("gfill");
      else exp_pair("gpair", b - 4, b, b == 7);
      idle();
      exp_none("gap");
      if (b >= 4) begin
        check("gap.top_i", 32'(bus.top_i), 32'(lanes(b - 4)));
        check("gap.bot_i", 32'(bus.bot_i), 32'(lanes(b)));
      end
    end

    // back-to-back blocks 0..15
    do_reset();
    for (int b = 0; b < 16; b++) begin
      beat(b);
      if (b % 8 < 4) exp_none("bb.fill");
      else exp_pair("bb.pair", b - 4, b, b % 8 == 7);
    end

    // flush with beat 5: dropped, data kept, restart on fresh beats
    do_reset();
    for (int b = 0; b < 5; b++) beat(b);
    exp_pair("fl.p0", 0, 4, 1'b0);
    drive(5, 1'b1, 1'b1, 1'b0);
    exp_none("fl");
    check("fl.phase", 32'(bus.phase), 32'd0);
    check("fl.top_i", 32'(bus.top_i), 32'(lanes(0)));
    for (int b = 100; b < 108; b++) begin
      beat(b);
      if (b < 104) exp_none("fl.fill");
      else exp_pair("fl.pair", b - 4, b, b == 107);
    end

    // reset at beat 6 during PAIR
    do_reset();
    for (int b = 0; b < 6; b++) beat(b);
    drive(6, 1'b1, 1'b0, 1'b1);
    exp_none("mr");
    check("mr.phase", 32'(bus.phase), 32'd0);
    check("mr.top", 32'({bus.top_q, bus.top_i}), 32'd0);
    check("mr.bot", 32'({bus.bot_q, bus.bot_i}), 32'd0);
    for (int b = 20; b < 28; b++) begin
      beat(b);
      if (b < 24) exp_none("mr.fill");
      else exp_pair("mr.pair", b - 4, b, b == 27);
    end

`ifdef BFLY_PAIR_BUF_BLKCNT_EN
    // three complete blocks then flush
    do_reset();
    check("bc.rst", 32'(bus.blk_cnt), 32'd0);
    for (int b = 0; b < 24; b++) beat(b);
    drive(0, 1'b0, 1'b1, 1'b0);
    check("bc.3", 32'(bus.blk_cnt), 32'd3);
    idle();
    idle();
    check("bc.hold", 32'(bus.blk_cnt), 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bfly_pair_buf.md
BFLY_PAIR_BUF -- requirements
Module: bfly_pair_buf

Interface
REQ-001 Parameter DATA_WIDTH, default 9, signed width of each I/Q sample.
REQ-002 Parameter LANES, default 16, number of parallel lanes per beat.
REQ-003 Parameter DEPTH, default 16, butterfly span in beats; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 din_valid  input  1  beat present on din_i/din_q this cycle.
REQ-007 din_i, din_q  input  LANES x DATA_WIDTH signed  parallel beat.
REQ-008 flush  input  1  synchronous block abort, one cycle.
REQ-009 top_i, top_q  output  LANES x DATA_WIDTH signed  earlier sample of butterfly pair, x[n].
REQ-010 bot_i, bot_q  output  LANES x DATA_WIDTH signed  later sample of butterfly pair, x[n+DEPTH].
REQ-011 pair_valid  output  1  top/bot hold a valid pair this cycle.
REQ-012 blk_last  output  1  pair is the final pair of a block.
REQ-013 phase  output  1  current FSM state: 0 = FILL, 1 = PAIR.

Function
REQ-014 A block is 2*DEPTH accepted beats, indexed b = 0..2*DEPTH-1; a beat is accepted when din_valid=1 and flush=0.
REQ-015 The delay line is DEPTH beats deep and shifts by one position per accepted beat only; it holds otherwise.
REQ-016 Before accepting beat b, the oldest delay-line entry is the beat accepted DEPTH beats earlier.
REQ-017 The FSM has states FILL and PAIR, with a beat counter of $clog2(DEPTH) bits.
REQ-018 FILL: each accepted beat increments the counter; the beat with counter = DEPTH-1 moves to PAIR and the counter wraps to 0.
REQ-019 PAIR: each accepted beat b registers top <= oldest entry (x[b-DEPTH]), bot <= din (x[b]), and pair_valid <= 1.
REQ-020 PAIR: the beat with counter = DEPTH-1 also sets blk_last <= 1, returns the FSM to FILL, and wraps the counter to 0.
REQ-021 Pair latency is exactly 1 cycle from the accepting edge; pair_valid and blk_last are single-cycle pulses per accepted beat.
REQ-022 Without an accepted beat, pair_valid=0 and blk_last=0; top and bot hold their last values.
REQ-023 Gaps in din_valid are allowed anywhere, and pairing stays by beat count, not cycle count.
REQ-024 Beats accepted in PAIR enter the delay line and are discarded at block wrap; the next block needs DEPTH fresh beats before any pair.
REQ-025 flush=1 forces FSM to FILL and counter to 0, and clears pair_valid and blk_last on the next cycle.
REQ-026 flush does not clear delay-line or top/bot data.
REQ-027 If flush and din_valid are both high, flush wins and the beat is dropped.
REQ-028 No arithmetic is performed on samples; data passes bit-exact.

Reset
REQ-029 rst=1 at a clock edge sets: FSM=FILL, counter=0, pair_valid=0, blk_last=0, phase=0, top/bot=0, delay line=0.
REQ-030 rst takes priority over flush and din_valid.
REQ-031 rst asserted mid-block discards the partial block; pairing restarts at b=0 after release.

Configuration
REQ-032 Macro BFLY_PAIR_BUF_BLKCNT_EN, when defined, adds output blk_cnt (16 bits, unsigned).
REQ-033 blk_cnt increments on each blk_last pulse and saturates at 16'hFFFF.
REQ-034 blk_cnt is cleared by rst only, not by flush.
REQ-035 Without BFLY_PAIR_BUF_BLKCNT_EN, the port and counter do not exist and all other behaviour is identical.

Structure
REQ-036 Package bfly_buf_pkg holds the FSM state enum (FILL, PAIR) and a function for counter width from DEPTH.
REQ-037 Sub-module bfly_delay_line implements the enable-gated DEPTH x LANES x DATA_WIDTH I/Q shift storage; bfly_pair_buf holds FSM, counter and output registers.

Verification (DEPTH=4, LANES=2, DATA_WIDTH=9 unless noted)
REQ-038 Beats 0..7 contiguous, lane0 din_i=b, lane1 din_i=-b -> pair_valid on 4 cycles after beats 4..7; top_i lane0=0,1,2,3; bot_i lane0=4,5,6,7; lane1 negated; blk_last only with pair 3/7.
REQ-039 Same stream with din_valid low every other cycle -> identical pair values; pair_valid only after accepting edges.
REQ-040 Two back-to-back blocks, values 0..15 -> second block pairs are (8,12),(9,13),(10,14),(11,15); no pair emitted during beats 8..11.
REQ-041 Flush concurrent with beat 5 -> beat 5 dropped, phase=0 next cycle; next 8 beats 100..107 pair as (100,104)..(103,107).
REQ-042 rst pulsed during PAIR at beat 6 -> all outputs 0 next cycle; the following block pairs correctly from fresh data.
REQ-043 With BFLY_PAIR_BUF_BLKCNT_EN defined, 3 complete blocks then flush -> blk_cnt=3 and stays 3; with the macro undefined, the build has no blk_cnt port.
